// File: rtl/clock_div_prog.sv
// clock_div_prog: runtime-programmable clock/tick divider with boundary-synchronous reconfiguration
module clock_div_prog #(
    parameter int CNT_WIDTH    = 16,
    parameter int DEFAULT_DIV  = 17,
    parameter int DEFAULT_HIGH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 resync,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] div_in,
    input  logic [CNT_WIDTH-1:0] high_in,
    output logic                 div_clock,
    output logic                 tick,
    output logic                 load_ack,
    output logic                 cfg_err
);
    localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] TWO      = CNT_WIDTH'(2);
    localparam logic [CNT_WIDTH-1:0] DIV_RST  = CNT_WIDTH'(DEFAULT_DIV);
    localparam logic [CNT_WIDTH-1:0] HIGH_RST = CNT_WIDTH'(DEFAULT_HIGH);
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt, div_q, high_q, shadow_div, shadow_high, eff_div, eff_high;
    logic pending, legal, wrap, restart, eff_pending, apply;
    // Validate the request and decide whether a config takes effect at this edge;
    // a legal load in the same cycle is visible to the apply decision directly.
    always_comb begin
        legal       = load && div_in >= TWO && high_in != '0 && high_in < div_in;
        wrap        = cnt == div_q - ONE;
        restart     = !enable || resync || wrap;
        eff_pending = pending || legal;
        eff_div     = legal ? div_in : shadow_div;
        eff_high    = legal ? high_in : shadow_high;
        apply       = eff_pending && restart;
        cnt_nxt     = restart ? '0 : cnt + ONE;
    end
    // Phase counter and registered outputs; idle rewinds to phase 0, resync suppresses the tick.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt       <= '0;
            div_clock <= 1'b0;
            tick      <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            div_clock <= enable && cnt < high_q;
            tick      <= enable && !resync && wrap;
        end
    end
    // Shadow/pending config and handshake pulses; active config only changes at a period boundary.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_q       <= DIV_RST;
            high_q      <= HIGH_RST;
            shadow_div  <= DIV_RST;
            shadow_high <= HIGH_RST;
            pending     <= 1'b0;
            load_ack    <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            shadow_div  <= eff_div;
            shadow_high <= eff_high;
            pending     <= eff_pending && !apply;
            load_ack    <= apply;
            cfg_err     <= load && !legal;
            if (apply) begin
                div_q  <= eff_div;
                high_q <= eff_high;
            end
        end
    end
endmodule

// File: tb/tb_clock_div_prog.sv
// tb_clock_div_prog: scoreboard bench for the programmable clock divider
module tb_clock_div_prog;
    logic clock = 1'b0, reset = 1'b1, enable = 1'b0, resync = 1'b0, load = 1'b0;
    logic [15:0] div_in = '0, high_in = '0;
    logic div_clock, tick, load_ack, cfg_err;
    int n_cmp = 0, n_err = 0;
    int m_cnt = 0, m_div = 17, m_high = 8, m_sdiv = 17, m_shigh = 8;
    bit m_pend = 1'b0;
    logic [3:0] exp_q[$];
    int n, hi;

    clock_div_prog dut (
        .clock(clock), .reset(reset), .enable(enable), .resync(resync), .load(load),
        .div_in(div_in), .high_in(high_in),
        .div_clock(div_clock), .tick(tick), .load_ack(load_ack), .cfg_err(cfg_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: model predicts {div_clock,tick,load_ack,cfg_err} from the driven inputs,
    // then the DUT result is popped and compared just after the edge.
    task automatic cyc();
        bit lg, wr, pend, ap;
        int sd, sh;
        lg = load && div_in >= 2 && high_in >= 1 && high_in < div_in;
        if (reset) begin
            exp_q.push_back(4'b0000);
            m_cnt = 0; m_div = 17; m_high = 8; m_sdiv = 17; m_shigh = 8; m_pend = 1'b0;
        end else begin
            wr = enable && (m_cnt == m_div - 1);
            pend = m_pend || lg;
            sd = lg ? int'(div_in) : m_sdiv;
            sh = lg ? int'(high_in) : m_shigh;
            ap = pend && (!enable || resync || wr);
            exp_q.push_back({enable && (m_cnt < m_high), wr && !resync, ap, load && !lg});
            m_cnt = (!enable || resync || wr) ? 0 : m_cnt + 1;
            m_sdiv = sd; m_shigh = sh; m_pend = pend && !ap;
            if (ap) begin m_div = sd; m_high = sh; end
        end
        @(posedge clock);
        #1;
        check("outs", {28'd0, div_clock, tick, load_ack, cfg_err}, {28'd0, exp_q.pop_front()});
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; resync = 1'b0; load = 1'b0;
        cyc();
        cyc();
        check("rst_outs", {div_clock, tick, load_ack, cfg_err}, 0);
        reset = 1'b0;
    endtask

    task automatic wait_cnt(input int c);
        for (int i = 0; i < 100 && m_cnt != c; i++) cyc();
        if (m_cnt != c) check("wait_cnt", m_cnt, c);
    endtask

    // Cycles until the DUT ticks (tick cycle included), counting div_clock high cycles.
    task automatic run_until_tick(output int cycles, output int high);
        bit seen = 1'b0;
        cycles = 0;
        high = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            cyc();
            cycles++;
            if (div_clock) high++;
            seen = tick;
        end
        if (!seen) check("tick_timeout", 0, 1);
    endtask

    task automatic do_load(input int d, input int h);
        load = 1'b1; div_in = 16'(d); high_in = 16'(h);
        cyc();
        load = 1'b0;
    endtask

    initial begin
        // 1: defaults 17/8
        do_reset();
        enable = 1'b1;
        run_until_tick(n, hi); check("t1_per", n, 17); check("t1_hi", hi, 8);
        run_until_tick(n, hi); check("t1_per2", n, 17); check("t1_hi2", hi, 8);
        // 2: legal load mid-period takes effect after the old period completes
        do_reset();
        enable = 1'b1;
        wait_cnt(5);
        do_load(4, 1);
        run_until_tick(n, hi); check("t2_tail", n, 11); check("t2_ack", load_ack, 1);
        run_until_tick(n, hi); check("t2_per", n, 4); check("t2_hi", hi, 1);
        run_until_tick(n, hi); check("t2_per2", n, 4); check("t2_hi2", hi, 1);
        // 3: illegal loads rejected
        do_reset();
        enable = 1'b1;
        do_load(1, 0); check("t3_err1", cfg_err, 1);
        do_load(5, 5); check("t3_err2", cfg_err, 1); check("t3_noack", load_ack, 0);
        run_until_tick(n, hi);
        run_until_tick(n, hi); check("t3_per", n, 17); check("t3_hi", hi, 8);
        // 4: load in the wrap cycle applies at that edge; odd divide
        do_reset();
        enable = 1'b1;
        wait_cnt(16);
        do_load(3, 2); check("t4_tick", tick, 1); check("t4_ack", load_ack, 1);
        run_until_tick(n, hi); check("t4_per", n, 3); check("t4_hi", hi, 2);
        run_until_tick(n, hi); check("t4_per2", n, 3); check("t4_hi2", hi, 2);
        // 5: resync and enable drop restart full periods
        do_reset();
        enable = 1'b1;
        wait_cnt(10);
        resync = 1'b1; cyc(); resync = 1'b0;
        check("t5_rs_clk", div_clock, 0); check("t5_rs_tick", tick, 0);
        run_until_tick(n, hi); check("t5_per", n, 17); check("t5_hi", hi, 8);
        wait_cnt(3);
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("t5_idle", {div_clock, tick}, 0);
        end
        enable = 1'b1;
        run_until_tick(n, hi); check("t5_per2", n, 17); check("t5_hi2", hi, 8);
        wait_cnt(16);
        resync = 1'b1; cyc(); resync = 1'b0;
        check("t5_wrap_rs", tick, 0);
        // 6: reset discards a pending load
        do_reset();
        enable = 1'b1;
        wait_cnt(5);
        do_load(4, 1);
        wait_cnt(8);
        reset = 1'b1; cyc(); reset = 1'b0;
        check("t6_rst", {div_clock, tick, load_ack, cfg_err}, 0);
        run_until_tick(n, hi); check("t6_per", n, 17); check("t6_hi", hi, 8);
        run_until_tick(n, hi); check("t6_per2", n, 17); check("t6_hi2", hi, 8);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
